// File: rtl/hwacc_sched_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// accelerator transaction scheduler.
package hwacc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RETIRE = 3'd4
  } sched_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_LEN_WIDTH      = 8;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Widest requester vector supported; narrower configurations zero-extend.
  localparam int MAX_REQ = 8;

  // One-hot grant of the first requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && req[idx[2:0]]) begin
          grant[idx[2:0]] = 1'b1;
          found           = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/hwacc_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant, its index and a valid flag.
module hwacc_rr_arbiter
  import hwacc_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [2:0]         w_ptr_ext;
  logic [MAX_REQ-1:0] w_pick;

  // Widen request and pointer to the helper's fixed width.
  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
    w_ptr_ext                = '0;
    w_ptr_ext[IDX_W-1:0]     = i_rr_ptr;
  end

  assign w_pick  = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
  assign o_grant = w_pick[NUM_REQ-1:0];
  assign o_valid = |w_pick;

  // Encode the one-hot pick into an index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/hwacc_txn_scheduler.sv
// Round-robin scheduler sharing one AXI4 master transaction engine among
// NUM_REQ requesters. Optional watchdog in WAIT enabled by the macro
// HWACC_SCHED_TIMEOUT_EN (TIMEOUT_CYCLES cycles, then retire as an error).
//
// state  | meaning
// IDLE   | no transaction; leave when any req is high
// ARB    | pick requester, capture its address/length
// LAUNCH | one-cycle start pulse to the engine
// WAIT   | wait for a done level that followed a low level
// RETIRE | done/err pulse, update counters and pointer
//
// All outputs are registered decodes of the current state, so they trail
// the state register by one cycle and are glitch-free toward the engine.
module hwacc_txn_scheduler
  import hwacc_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          txn_init,
  output logic [ADDR_WIDTH-1:0]         txn_addr,
  output logic [LEN_WIDTH-1:0]          txn_len,
  input  logic                          txn_done,
  input  logic                          txn_error,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          txn_count,
  output logic [CNT_WIDTH-1:0]          err_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_seen_low;
  logic             r_err_lat;

  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]    r_done, w_done_nxt;
  logic [NUM_REQ-1:0]    r_err, w_err_nxt;
  logic                  r_init, w_init_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [ADDR_WIDTH-1:0] r_txn_addr, w_txn_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_txn_len, w_txn_len_nxt;
  logic [CNT_WIDTH-1:0]  r_txn_cnt, w_txn_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_err_cnt, w_err_cnt_nxt;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic               w_txn_qual;
  logic               w_tmo_hit;

  hwacc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_vld)
  );

  // A done level counts only after a low level was seen in this WAIT.
  assign w_txn_qual = (r_state == WAIT) && txn_done && r_seen_low;

`ifdef HWACC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog down-counter: loaded in LAUNCH, terminal count at zero in WAIT.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_tmo_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if ((r_state == WAIT) && (r_tmo_cnt != '0)) begin
      r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_state == WAIT) && !w_txn_qual && (r_tmo_cnt == '0);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = ARB;
      ARB:     w_state_nxt = w_pick_vld ? LAUNCH : IDLE;
      LAUNCH:  w_state_nxt = WAIT;
      WAIT:    if (w_txn_qual || w_tmo_hit) w_state_nxt = RETIRE;
      RETIRE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    w_grant_nxt    = r_grant;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    w_init_nxt     = 1'b0;
    w_busy_nxt     = (r_state != IDLE);
    w_txn_addr_nxt = r_txn_addr;
    w_txn_len_nxt  = r_txn_len;
    w_txn_cnt_nxt  = r_txn_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    case (r_state)
      IDLE: w_grant_nxt = '0;
      ARB: begin
        if (w_pick_vld) begin
          w_grant_nxt    = w_pick_oh;
          w_txn_addr_nxt = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          w_txn_len_nxt  = req_len[int'(w_pick_idx)*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      LAUNCH: w_init_nxt = 1'b1;
      RETIRE: begin
        if (r_err_lat) begin
          w_err_nxt = r_grant;
          if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + CNT_WIDTH'(1);
        end else begin
          w_done_nxt = r_grant;
          if (r_txn_cnt != '1) w_txn_cnt_nxt = r_txn_cnt + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_init     <= 1'b0;
      r_busy     <= 1'b0;
      r_txn_addr <= '0;
      r_txn_len  <= '0;
      r_txn_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_init     <= w_init_nxt;
      r_busy     <= w_busy_nxt;
      r_txn_addr <= w_txn_addr_nxt;
      r_txn_len  <= w_txn_len_nxt;
      r_txn_cnt  <= w_txn_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // Transaction bookkeeping: granted index, stale-done guard, result, pointer.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_seen_low <= 1'b0;
      r_err_lat  <= 1'b0;
    end else begin
      case (r_state)
        ARB:    if (w_pick_vld) r_idx <= w_pick_idx;
        LAUNCH: r_seen_low <= 1'b0;
        WAIT: begin
          if (!txn_done) r_seen_low <= 1'b1;
          if (w_txn_qual)     r_err_lat <= txn_error;
          else if (w_tmo_hit) r_err_lat <= 1'b1;
        end
        RETIRE: begin
          if (r_idx == IDX_W'(NUM_REQ - 1)) r_rr_ptr <= '0;
          else                              r_rr_ptr <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign err       = r_err;
  assign txn_init  = r_init;
  assign busy      = r_busy;
  assign txn_addr  = r_txn_addr;
  assign txn_len   = r_txn_len;
  assign txn_count = r_txn_cnt;
  assign err_count = r_err_cnt;

endmodule
